seq_verify_n: RTL and testbench

- Parametrised successor of the `verify` ASCII sequence checker.
- Consumes a character stream (one byte per `char_valid` strobe) framed by NUL bytes and checks sequences of the form `{` A op B `}`.
  - A and B are DIGITS hex characters each.
  - op is drawn from a configurable operator set.
- Outputs:
  - A paced verdict (`sequence_valid` + `output_strobe`).
  - An error code and the character index of the first error.
  - The decoded operands and opcode.
  - A running count of valid sequences.
- Sits between the UART RX byte stream and the TX/report logic.

---
 rtl/seq_verify_pkg.sv | 50 +++++
 rtl/seq_verify_n_pacer.sv | 37 +++
 rtl/seq_verify_n.sv | 155 +++++++++++++++
 tb/tb_seq_verify_n.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_verify_pkg.sv
// Shared types and constants for the framed ASCII sequence checker.
// Holds FSM states, error codes, character constants and hex decode.
package seq_verify_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPA,
        S_OP,
        S_OPB,
        S_CLOSE,
        S_ERR
    } state_t;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_A     = 3'd1;
    localparam logic [2:0] E_OP    = 3'd2;
    localparam logic [2:0] E_B     = 3'd3;
    localparam logic [2:0] E_CLOSE = 3'd4;
    localparam logic [2:0] E_TRUNC = 3'd5;

    localparam logic [7:0] C_NUL   = 8'h00;
    localparam logic [7:0] C_OPEN  = 8'h7B;
    localparam logic [7:0] C_SHUT  = 8'h7D;
    localparam logic [7:0] C_PLUS  = 8'h2B;
    localparam logic [7:0] C_MINUS = 8'h2D;
    localparam logic [7:0] C_STAR  = 8'h2A;

    // Returns {valid, nibble}; nibble is 0 when the char is not hex.
    function automatic logic [4:0] is_hex(
        input logic [7:0] c,
        input logic       allow_lower
    );
        logic [7:0] d;
        d = 8'h00;
        if (c >= 8'h30 && c <= 8'h39) begin
            d = c - 8'h30;
            return {1'b1, d[3:0]};
        end
        if (c >= 8'h41 && c <= 8'h46) begin
            d = c - 8'h37;
            return {1'b1, d[3:0]};
        end
        if (allow_lower && c >= 8'h61 && c <= 8'h66) begin
            d = c - 8'h57;
            return {1'b1, d[3:0]};
        end
        return 5'd0;
    endfunction

endpackage

// File: rtl/seq_verify_n_pacer.sv
// Spaces verdict strobes at least GAP clocks apart.
// Holds a single pending request while the gap counter is running.
import seq_verify_pkg::*;

module strobe_pacer #(
    parameter int GAP = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic strobe
);

    localparam int CW = (GAP > 2) ? $clog2(GAP) : 1;
    localparam int LD = (GAP > 0) ? GAP - 1 : 0;

    logic [CW-1:0] cnt;
    logic          pending;

    assign strobe = (req || pending) && (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
        end else if (strobe) begin
            cnt     <= CW'(LD);
            pending <= 1'b0;
        end else begin
            if (cnt != '0)
                cnt <= cnt - 1'b1;
            if (req)
                pending <= 1'b1;
        end
    end

endmodule

// File: rtl/seq_verify_n.sv
// Checks NUL-framed "{A op B}" sequences on a byte stream.
// Registers a verdict per sequence and paces its announcement strobe.
import seq_verify_pkg::*;

module seq_verify_n #(
    parameter int          freq         = 200,
    parameter int          UART_TX_baud = 20,
    parameter int          DIGITS       = 4,
    parameter logic [2:0]  OP_MASK      = 3'b011,
    parameter bit          ALLOW_LOWER  = 1'b0,
    parameter int          CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            ascii_char,
    input  logic                  char_valid,
    output logic                  sequence_valid,
    output logic                  output_strobe,
    output logic [2:0]            err_code,
    output logic [4:0]            err_pos,
    output logic [4*DIGITS-1:0]   operand_a,
    output logic [4*DIGITS-1:0]   operand_b,
    output logic [1:0]            op_code,
    output logic [CNT_W-1:0]      valid_count
);

    localparam int W   = 4 * DIGITS;
    localparam int GAP = (UART_TX_baud > 0 && freq >= UART_TX_baud)
                       ? freq / UART_TX_baud : 1;

    state_t         state;
    logic [2:0]     dcnt;
    logic [W-1:0]   acc_a;
    logic [W-1:0]   acc_b;
    logic [1:0]     op_r;
    logic [4:0]     pos;
    logic           vpulse;

    logic [4:0]     hx;
    logic           op_ok;
    logic [1:0]     op_dec;
    logic [4:0]     pos_nx;
    logic           last;

    assign hx     = is_hex(ascii_char, ALLOW_LOWER);
    assign pos_nx = (pos == 5'd31) ? pos : pos + 5'd1;
    assign last   = (dcnt == 3'(DIGITS - 1));

    always_comb begin
        op_ok  = 1'b0;
        op_dec = 2'd0;
        case (ascii_char)
            C_PLUS:  begin op_ok = OP_MASK[0]; op_dec = 2'd0; end
            C_MINUS: begin op_ok = OP_MASK[1]; op_dec = 2'd1; end
            C_STAR:  begin op_ok = OP_MASK[2]; op_dec = 2'd2; end
            default: begin op_ok = 1'b0;       op_dec = 2'd0; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            dcnt           <= '0;
            acc_a          <= '0;
            acc_b          <= '0;
            op_r           <= '0;
            pos            <= '0;
            vpulse         <= 1'b0;
            sequence_valid <= 1'b0;
            err_code       <= E_NONE;
            err_pos        <= '0;
            operand_a      <= '0;
            operand_b      <= '0;
            op_code        <= '0;
            valid_count    <= '0;
        end else begin
            vpulse <= 1'b0;
            if (char_valid && ascii_char == C_NUL) begin
                if (state != S_IDLE && state != S_ERR) begin
                    vpulse         <= 1'b1;
                    sequence_valid <= 1'b0;
                    err_code       <= E_TRUNC;
                    err_pos        <= pos;
                end
                state <= S_IDLE;
            end else if (char_valid) begin
                case (state)
                    S_IDLE: if (ascii_char == C_OPEN) begin
                        dcnt  <= '0;
                        acc_a <= '0;
                        acc_b <= '0;
                        pos   <= 5'd1;
                        state <= S_OPA;
                    end
                    S_OPA, S_OPB: if (hx[4]) begin
                        if (state == S_OPA)
                            acc_a <= (acc_a << 4) | W'(hx[3:0]);
                        else
                            acc_b <= (acc_b << 4) | W'(hx[3:0]);
                        pos  <= pos_nx;
                        dcnt <= last ? 3'd0 : dcnt + 3'd1;
                        if (last)
                            state <= (state == S_OPA) ? S_OP : S_CLOSE;
                    end else begin
                        vpulse         <= 1'b1;
                        sequence_valid <= 1'b0;
                        err_code       <= (state == S_OPA) ? E_A : E_B;
                        err_pos        <= pos;
                        state          <= S_ERR;
                    end
                    S_OP: if (op_ok) begin
                        op_r  <= op_dec;
                        pos   <= pos_nx;
                        state <= S_OPB;
                    end else begin
                        vpulse         <= 1'b1;
                        sequence_valid <= 1'b0;
                        err_code       <= E_OP;
                        err_pos        <= pos;
                        state          <= S_ERR;
                    end
                    S_CLOSE: begin
                        vpulse <= 1'b1;
                        if (ascii_char == C_SHUT) begin
                            sequence_valid <= 1'b1;
                            err_code       <= E_NONE;
                            err_pos        <= '0;
                            operand_a      <= acc_a;
                            operand_b      <= acc_b;
                            op_code        <= op_r;
                            valid_count    <= valid_count + 1'b1;
                            state          <= S_IDLE;
                        end else begin
                            sequence_valid <= 1'b0;
                            err_code       <= E_CLOSE;
                            err_pos        <= pos;
                            state          <= S_ERR;
                        end
                    end
                    default: state <= state;
                endcase
            end
        end
    end

    strobe_pacer #(
        .GAP (GAP)
    ) u_pacer (
        .clk    (clk),
        .rst    (rst),
        .req    (vpulse),
        .strobe (output_strobe)
    );

endmodule

// File: tb/tb_seq_verify_n.sv
// Directed checks of seq_verify_n: default, wide-op and lowercase builds
// share one stimulus stream; pacing and reset run on the default build.
module tb_seq_verify_n;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ch  = 8'h00;
    logic        cv  = 1'b0;

    logic        sv0, st0, sv1, st1, sv2, st2;
    logic [2:0]  ec0, ec1, ec2;
    logic [4:0]  ep0, ep1, ep2;
    logic [15:0] a0, b0, a1, b1, a2, b2;
    logic [1:0]  op0, op1, op2;
    logic [7:0]  vc0, vc1, vc2;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int stb_n = 0;
    int last_t = 0;
    int last_gap = 0;
    int min_gap = 1000;
    logic [2:0] stb_err;
    logic [4:0] stb_pos;

    always #5 clk = ~clk;

    seq_verify_n u0 (
        .clk(clk), .rst(rst), .ascii_char(ch), .char_valid(cv),
        .sequence_valid(sv0), .output_strobe(st0),
        .err_code(ec0), .err_pos(ep0),
        .operand_a(a0), .operand_b(b0),
        .op_code(op0), .valid_count(vc0)
    );

    seq_verify_n #(.OP_MASK(3'b111)) u1 (
        .clk(clk), .rst(rst), .ascii_char(ch), .char_valid(cv),
        .sequence_valid(sv1), .output_strobe(st1),
        .err_code(ec1), .err_pos(ep1),
        .operand_a(a1), .operand_b(b1),
        .op_code(op1), .valid_count(vc1)
    );

    seq_verify_n #(.ALLOW_LOWER(1'b1)) u2 (
        .clk(clk), .rst(rst), .ascii_char(ch), .char_valid(cv),
        .sequence_valid(sv2), .output_strobe(st2),
        .err_code(ec2), .err_pos(ep2),
        .operand_a(a2), .operand_b(b2),
        .op_code(op2), .valid_count(vc2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (st0) begin
            if (stb_n > 0) begin
                last_gap = cyc - last_t;
                if (last_gap < min_gap)
                    min_gap = last_gap;
            end
            last_t  = cyc;
            stb_err = ec0;
            stb_pos = ep0;
            stb_n++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input int tr);
        @(negedge clk);
        ch = c;
        cv = 1'b1;
        @(negedge clk);
        cv = 1'b0;
        repeat (tr - 2) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int tr);
        for (int i = 0; i < s.len(); i++)
            send(s[i], tr);
    endtask

    task automatic frame(input string s);
        send(8'h00, 10);
        send_str(s, 10);
        send(8'h00, 10);
        repeat (2) @(negedge clk);
    endtask

    int base;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_sv", sv0, 0);
        chk("rst_ec", ec0, 0);
        chk("rst_vc", vc0, 0);
        chk("rst_stb", st0, 0);
        rst = 1'b0;

        base = stb_n;
        frame("{1A2B+3C4D}");
        chk("s1_stb", stb_n - base, 1);
        chk("s1_sv", sv0, 1);
        chk("s1_a", a0, 32'h1A2B);
        chk("s1_b", b0, 32'h3C4D);
        chk("s1_op", op0, 0);
        chk("s1_vc", vc0, 1);
        chk("s1_ec", ec0, 0);

        base = stb_n;
        frame("{FF00-00FF}");
        chk("s2_stb", stb_n - base, 1);
        chk("s2_sv", sv0, 1);
        chk("s2_op", op0, 1);
        chk("s2_a", a0, 32'hFF00);
        chk("s2_b", b0, 32'h00FF);
        chk("s2_vc", vc0, 2);

        base = stb_n;
        frame("{1X2Y+3Z4W}");
        chk("s3_stb", stb_n - base, 1);
        chk("s3_sv", sv0, 0);
        chk("s3_ec", ec0, 1);
        chk("s3_ep", ep0, 2);
        chk("s3_a", a0, 32'hFF00);
        chk("s3_vc", vc0, 2);

        frame("{1A2B*3C4D}");
        chk("s4_ec", ec0, 2);
        chk("s4_ep", ep0, 5);
        chk("s4w_sv", sv1, 1);
        chk("s4w_op", op1, 2);
        chk("s4w_vc", vc1, 3);

        frame("{1A2");
        chk("s5_sv", sv0, 0);
        chk("s5_ec", ec0, 5);
        chk("s5_ep", ep0, 4);

        frame("{abcd+0001}");
        chk("s6l_sv", sv2, 1);
        chk("s6l_a", a2, 32'hABCD);
        chk("s6l_b", b2, 32'h0001);
        chk("s6l_vc", vc2, 3);
        chk("s6_ec", ec0, 1);
        chk("s6_ep", ep0, 1);

        // second verdict lands 6 clocks after the first strobe
        base = stb_n;
        send_str("{0001+0002}", 2);
        send(8'h00, 2);
        send_str("{G", 2);
        send(8'h00, 2);
        repeat (20) @(negedge clk);
        chk("pa_stb", stb_n - base, 2);
        chk("pa_gap", last_gap, 10);
        chk("pa_ec", stb_err, 1);
        chk("pa_ep", stb_pos, 1);
        chk("pa_vc", vc0, 3);

        // pending truncation verdict is discarded by reset
        base = stb_n;
        send_str("{0001+0002}", 2);
        send_str("{1", 2);
        send(8'h00, 2);
        send(8'h7B, 2);
        chk("pb_ec", ec0, 5);
        chk("pb_vc", vc0, 4);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("pb_rvc", vc0, 0);
        chk("pb_rec", ec0, 0);
        chk("pb_rep", ep0, 0);
        chk("pb_ra", a0, 0);
        chk("pb_rb", b0, 0);
        chk("pb_rsv", sv0, 0);
        repeat (40) @(negedge clk);
        chk("pb_stb", stb_n - base, 1);
        chk("min_gap", min_gap >= 10, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
